// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader:
// FSM encoding, handshake byte values and frame field widths.
package uart_prog_loader_pkg;

    localparam int CNT_W = 16;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        WAIT_CNT,
        LOAD,
        CHECK,
        DONE,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/uart_prog_loader_timeout.sv
// Loadable inter-byte down-counter; expired stays high once the
// armed count has run out, until the next load or clear.
module loader_timeout #(
    parameter int CYCLES = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic load,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;
    logic         armed;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= W'(CYCLES - 1);
            armed <= 1'b1;
        end else if (armed && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = armed && (cnt == '0);

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a counted, checksummed program image over UART bytes,
// writes it to instruction memory, then releases the CPU on start.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int CHECKSUM_EN = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              restart,
    input  logic              start,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    output logic              cpu_rst,
    output logic              cpu_run_enable,
    output logic              loading,
    output logic              load_err
);

    localparam int NB = DATA_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state, nxt;
    logic              have_lo;
    logic [7:0]        count_lo;
    logic [CNT_W-1:0]  count, word_cnt, cnt_full;
    logic [BW-1:0]     byte_idx;
    logic [DATA_W-1:0] word, word_nxt;
    logic [7:0]        csum;
    logic              busy, take, tmo, last_byte, last_word;

    assign busy      = (state == WAIT_CNT) || (state == LOAD) || (state == CHECK);
    assign take      = rx_valid && !restart && busy;
    assign cnt_full  = {rx_byte, count_lo};
    assign last_byte = (byte_idx == BW'(NB - 1));
    assign last_word = ((word_cnt + 1'b1) == count);

    loader_timeout #(.CYCLES(TIMEOUT_CYC)) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (restart),
        .load    (take),
        .expired (tmo)
    );

    always_comb begin
        word_nxt = word;
        word_nxt[8*byte_idx +: 8] = rx_byte;
    end

    always_comb begin
        nxt = state;
        if (restart) begin
            nxt = WAIT_CNT;
        end else begin
            unique case (state)
                WAIT_CNT:
                    if (rx_valid) begin
                        if (have_lo) begin
                            if (cnt_full == '0)
                                nxt = DONE;
                            else if ({16'd0, cnt_full} > DEPTH)
                                nxt = ERR;
                            else
                                nxt = LOAD;
                        end
                    end else if (tmo) begin
                        nxt = ERR;
                    end
                LOAD:
                    if (rx_valid) begin
                        if (last_byte && last_word)
                            nxt = (CHECKSUM_EN != 0) ? CHECK : DONE;
                    end else if (tmo) begin
                        nxt = ERR;
                    end
                CHECK:
                    if (rx_valid)
                        nxt = (rx_byte == csum) ? DONE : ERR;
                    else if (tmo)
                        nxt = ERR;
                DONE:
                    if (start) nxt = RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= WAIT_CNT;
            have_lo        <= 1'b0;
            count_lo       <= '0;
            count          <= '0;
            word_cnt       <= '0;
            byte_idx       <= '0;
            word           <= '0;
            csum           <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            tx_byte        <= '0;
            tx_valid       <= 1'b0;
            cpu_rst        <= 1'b1;
            cpu_run_enable <= 1'b0;
            loading        <= 1'b1;
            load_err       <= 1'b0;
        end else begin
            state          <= nxt;
            cpu_rst        <= !(nxt == DONE || nxt == RUN);
            loading        <= !(nxt == DONE || nxt == RUN);
            cpu_run_enable <= (nxt == RUN);
            load_err       <= (nxt == ERR);
            mem_we         <= 1'b0;
            if (tx_valid && tx_ready)
                tx_valid <= 1'b0;
            if (restart) begin
                have_lo  <= 1'b0;
                word_cnt <= '0;
                byte_idx <= '0;
                csum     <= '0;
                tx_valid <= 1'b0;
            end else begin
                if (nxt != state && nxt == DONE) begin
                    tx_byte  <= ACK;
                    tx_valid <= 1'b1;
                end
                if (nxt != state && nxt == ERR) begin
                    tx_byte  <= NAK;
                    tx_valid <= 1'b1;
                end
                if (rx_valid) begin
                    unique case (state)
                        WAIT_CNT:
                            if (!have_lo) begin
                                count_lo <= rx_byte;
                                have_lo  <= 1'b1;
                            end else begin
                                count   <= cnt_full;
                                have_lo <= 1'b0;
                            end
                        LOAD: begin
                            csum <= csum + rx_byte;
                            word <= word_nxt;
                            if (last_byte) begin
                                byte_idx  <= '0;
                                word_cnt  <= word_cnt + 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= word_cnt[ADDR_W-1:0];
                                mem_wdata <= word_nxt;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader
// (DATA_W=16, ADDR_W=8, CHECKSUM_EN=1, TIMEOUT_CYC=1000).
module tb_uart_prog_loader;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        restart = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        cpu_rst;
    logic        cpu_run_enable;
    logic        loading;
    logic        load_err;

    always #5 CLK = ~CLK;

    uart_prog_loader #(
        .DATA_W(16), .ADDR_W(8), .CHECKSUM_EN(1), .TIMEOUT_CYC(1000)
    ) dut (
        .CLK(CLK), .RESET(RESET), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .restart(restart), .start(start), .tx_ready(tx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .cpu_rst(cpu_rst),
        .cpu_run_enable(cpu_run_enable), .loading(loading), .load_err(load_err)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    always @(negedge CLK)
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1; tick(1); restart = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic good_frame();
        send(8'h02); send(8'h00);
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        send(8'h14);
    endtask

    initial begin
        int bad;
        logic [7:0] b;

        // reset state
        tick(2);
        chk("rst_loading", loading, 1);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_run_en", cpu_run_enable, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        RESET = 1'b0;
        tick(1);

        // good two-word frame
        good_frame();
        chk("good_tx_valid", tx_valid, 1);
        chk("good_tx_byte", tx_byte, 8'h06);
        chk("good_loading", loading, 0);
        chk("good_cpu_rst", cpu_rst, 0);
        chk("good_run_en_pre", cpu_run_enable, 0);
        tick(2);
        chk("good_nwrites", wa.size(), 2);
        chk("good_a0", wa[0], 0);
        chk("good_d0", wd[0], 16'h1234);
        chk("good_a1", wa[1], 1);
        chk("good_d1", wd[1], 16'h5678);

        // ack held while tx_ready low
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_byte !== 8'h06) bad++;
            tick(1);
        end
        chk("hold_ack", bad, 0);
        tx_ready = 1'b1;
        chk("hold_last", tx_valid, 1);
        tick(1);
        tx_ready = 1'b0;
        chk("ack_drop", tx_valid, 0);

        pulse_start();
        chk("run_en", cpu_run_enable, 1);
        chk("run_cpu_rst", cpu_rst, 0);
        send(8'h05);
        tick(2);
        chk("run_rx_ignored", wa.size(), 2);
        chk("run_stays", cpu_run_enable, 1);

        pulse_restart();
        chk("rs_cpu_rst", cpu_rst, 1);
        chk("rs_loading", loading, 1);
        chk("rs_run_en", cpu_run_enable, 0);

        // bad checksum
        wa.delete(); wd.delete();
        send(8'h02); send(8'h00);
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        send(8'h15);
        tick(2);
        chk("bad_nwrites", wa.size(), 2);
        chk("bad_load_err", load_err, 1);
        chk("bad_tx_byte", tx_byte, 8'h15);
        chk("bad_tx_valid", tx_valid, 1);
        chk("bad_cpu_rst", cpu_rst, 1);
        pulse_start();
        chk("bad_start_ign", cpu_run_enable, 0);
        chk("bad_still_err", load_err, 1);
        pulse_restart();
        chk("bad_rs_err", load_err, 0);
        chk("bad_rs_txv", tx_valid, 0);

        // zero count
        wa.delete(); wd.delete();
        send(8'h00); send(8'h00);
        chk("zero_loading", loading, 0);
        chk("zero_tx", tx_byte, 8'h06);
        tick(2);
        chk("zero_nwrites", wa.size(), 0);
        pulse_restart();

        // count 257 > DEPTH
        send(8'h01); send(8'h01);
        chk("big_err", load_err, 1);
        chk("big_tx", tx_byte, 8'h15);
        tick(2);
        chk("big_nwrites", wa.size(), 0);
        pulse_restart();

        // inter-byte timeout
        send(8'h01); send(8'h00); send(8'h34);
        tick(999);
        chk("tmo_before", load_err, 0);
        tick(1);
        chk("tmo_err", load_err, 1);
        chk("tmo_nak", tx_byte, 8'h15);
        chk("tmo_nwrites", wa.size(), 0);
        pulse_restart();
        chk("tmo_rs", load_err, 0);
        tick(1100);
        chk("idle_no_tmo", load_err, 0);
        good_frame();
        tick(2);
        chk("tmo_after_ack", tx_byte, 8'h06);
        chk("tmo_after_ld", loading, 0);
        chk("tmo_after_n", wa.size(), 2);
        pulse_restart();

        // restart colliding with a mid-word byte
        wa.delete(); wd.delete();
        send(8'h01); send(8'h00); send(8'h34);
        rx_byte = 8'h12; rx_valid = 1'b1; restart = 1'b1;
        tick(1);
        rx_valid = 1'b0; restart = 1'b0;
        tick(3);
        chk("coll_nwrites", wa.size(), 0);
        chk("coll_loading", loading, 1);
        send(8'h01); send(8'h00); send(8'hAB); send(8'hCD); send(8'h78);
        tick(2);
        chk("coll_nw2", wa.size(), 1);
        chk("coll_d0", wd[0], 16'hCDAB);
        chk("coll_ack", tx_byte, 8'h06);
        chk("coll_err", load_err, 0);

        // reset mid-load
        pulse_restart();
        wa.delete(); wd.delete();
        send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
        RESET = 1'b1; tick(1); RESET = 1'b0;
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_cpu", cpu_rst, 1);
        chk("mid_rst_txv", tx_valid, 0);
        send(8'h44); send(8'h55); send(8'h66);
        tick(3);
        chk("mid_rst_nw", wa.size(), 1);
        chk("mid_rst_d0", wd[0], 16'h2211);
        RESET = 1'b1; tick(1); RESET = 1'b0;

        // count exactly DEPTH
        wa.delete(); wd.delete();
        send(8'h00); send(8'h01);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            send(b);
            send(~b);
        end
        send(8'h00);
        tick(2);
        chk("depth_nw", wa.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < wa.size(); i++) begin
            b = i[7:0];
            if (wa[i] !== b || wd[i] !== {~b, b}) bad++;
        end
        chk("depth_entries", bad, 0);
        if (wa.size() == 256) begin
            chk("depth_last_a", wa[255], 8'hFF);
            chk("depth_last_d", wd[255], 16'h00FF);
        end
        chk("depth_ack", tx_byte, 8'h06);
        chk("depth_loading", loading, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
